cancel_accumulator: RTL and testbench



---
 rtl/cancel_accumulator.sv | 132 +++++++++++++
 tb/tb_cancel_accumulator.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cancel_accumulator.sv
// Per-client cancelled-quantity accumulator: read-modify-write over a dual-port RAM with a one-deep bypass.
// Define CANCEL_ACC_SATURATE_EN to saturate the running total instead of wrapping.
module cancel_accumulator #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 4,
  parameter int A_MAX   = 16,
  parameter logic [D_WIDTH-1:0] LIMIT = 32'd1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] in_client,
  input  logic [D_WIDTH-1:0] in_qty,
  input  logic               in_clear,
  output logic [A_WIDTH-1:0] address_read,
  input  logic [D_WIDTH-1:0] data_read,
  output logic [A_WIDTH-1:0] address_write,
  output logic [D_WIDTH-1:0] data_write,
  output logic               write_enable,
  output logic               init_done,
  output logic               alert_valid,
  output logic [A_WIDTH-1:0] alert_client
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [A_WIDTH:0] COUNT_END = (A_WIDTH+1)'(A_MAX);
  localparam logic [A_WIDTH:0] COUNT_ONE = (A_WIDTH+1)'(1);

  state_t             r_state;
  logic [A_WIDTH:0]   r_count;
  logic               r_initWe;
  logic               r_ready;
  logic               r_initDone;
  logic [A_WIDTH-1:0] r_addrHold;
  logic [D_WIDTH-1:0] r_dataHold;
  logic               r_s1Valid;
  logic [A_WIDTH-1:0] r_s1Client;
  logic [D_WIDTH-1:0] r_s1Qty;
  logic               r_s1Clear;
  logic               r_bypValid;
  logic [A_WIDTH-1:0] r_bypClient;
  logic [D_WIDTH-1:0] r_bypData;
  logic               r_alertValid;
  logic [A_WIDTH-1:0] r_alertClient;

  logic               w_s1Live;
  logic [D_WIDTH-1:0] w_base;
  logic [D_WIDTH-1:0] w_added;
  logic [D_WIDTH-1:0] w_new;
  logic               w_alert;

  // The RAM returns stale data when reading the address written on the same edge, so the last write is forwarded.
  assign w_s1Live = r_s1Valid & ~reset;
  assign w_base   = (r_bypValid && (r_bypClient == r_s1Client)) ? r_bypData : data_read;

`ifdef CANCEL_ACC_SATURATE_EN
  logic [D_WIDTH:0] w_sum;
  assign w_sum   = {1'b0, w_base} + {1'b0, r_s1Qty};
  assign w_added = w_sum[D_WIDTH] ? {D_WIDTH{1'b1}} : w_sum[D_WIDTH-1:0];
`else
  assign w_added = w_base + r_s1Qty;
`endif

  assign w_new   = r_s1Clear ? '0 : w_added;
  assign w_alert = w_s1Live & ~r_s1Clear & (w_base < LIMIT) & (w_new >= LIMIT);

  // An in-flight write is suppressed while reset is asserted so a dropped event never reaches the RAM.
  assign address_read  = reset ? '0 : in_client;
  assign write_enable  = ~reset & (r_initWe | r_s1Valid);
  assign address_write = w_s1Live ? r_s1Client : r_addrHold;
  assign data_write    = w_s1Live ? w_new : r_dataHold;
  assign in_ready      = r_ready;
  assign init_done     = r_initDone;
  assign alert_valid   = r_alertValid;
  assign alert_client  = r_alertClient;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= INIT;
      r_count       <= '0;
      r_initWe      <= 1'b0;
      r_ready       <= 1'b0;
      r_initDone    <= 1'b0;
      r_addrHold    <= '0;
      r_dataHold    <= '0;
      r_s1Valid     <= 1'b0;
      r_s1Client    <= '0;
      r_s1Qty       <= '0;
      r_s1Clear     <= 1'b0;
      r_bypValid    <= 1'b0;
      r_bypClient   <= '0;
      r_bypData     <= '0;
      r_alertValid  <= 1'b0;
      r_alertClient <= '0;
    end else if (r_state == INIT) begin
      // Sweep writes zero to every address; the extra cycle after the last one hands over to RUN.
      r_s1Valid    <= 1'b0;
      r_bypValid   <= 1'b0;
      r_alertValid <= 1'b0;
      if (r_count < COUNT_END) begin
        r_initWe   <= 1'b1;
        r_addrHold <= r_count[A_WIDTH-1:0];
        r_dataHold <= '0;
        r_count    <= r_count + COUNT_ONE;
      end else begin
        r_initWe   <= 1'b0;
        r_state    <= RUN;
        r_ready    <= 1'b1;
        r_initDone <= 1'b1;
      end
    end else begin
      r_s1Valid  <= in_valid & r_ready;
      r_s1Client <= in_client;
      r_s1Qty    <= in_qty;
      r_s1Clear  <= in_clear;
      r_bypValid <= r_s1Valid;
      if (r_s1Valid) begin
        r_addrHold  <= r_s1Client;
        r_dataHold  <= w_new;
        r_bypClient <= r_s1Client;
        r_bypData   <= w_new;
      end
      r_alertValid <= w_alert;
      if (w_alert) begin
        r_alertClient <= r_s1Client;
      end
    end
  end

endmodule

// File: tb/tb_cancel_accumulator.sv
// Directed testbench for cancel_accumulator with a behavioural dual-port RAM (registered read, old data on same-edge write).
module tb_cancel_accumulator;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_client;
  logic [31:0] in_qty;
  logic        in_clear;
  logic [3:0]  address_read;
  logic [31:0] data_read;
  logic [3:0]  address_write;
  logic [31:0] data_write;
  logic        write_enable;
  logic        init_done;
  logic        alert_valid;
  logic [3:0]  alert_client;

  logic [31:0] mem [16];
  logic        fillGarbage;
  logic        badWrite4;
  int          checks;
  int          failures;

`ifdef CANCEL_ACC_SATURATE_EN
  localparam logic [31:0] SAT_DATA = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] SAT_DATA = 32'h0000_0010;
`endif

  typedef struct {
    logic        valid;
    logic [3:0]  client;
    logic [31:0] qty;
    logic        clear;
    logic        expWe;
    logic [3:0]  expAddr;
    logic [31:0] expData;
    logic        expAlert;
    logic [3:0]  expAlertClient;
  } vec_t;

  vec_t vecs[$];

  cancel_accumulator dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_client(in_client), .in_qty(in_qty), .in_clear(in_clear),
    .address_read(address_read), .data_read(data_read),
    .address_write(address_write), .data_write(data_write), .write_enable(write_enable),
    .init_done(init_done), .alert_valid(alert_valid), .alert_client(alert_client)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fillGarbage) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (write_enable) begin
      mem[address_write] <= data_write;
    end
    data_read <= mem[address_read];
    if (write_enable && address_write == 4'd4 && data_write != 32'd0) badWrite4 <= 1'b1;
  end

  function automatic vec_t mkVec(input int v, input int c, input int q, input int clr,
                                 input int we, input int a, input int d, input int al, input int ac);
    vec_t m;
    m.valid = (v != 0);
    m.client = 4'(c);
    m.qty = 32'(q);
    m.clear = (clr != 0);
    m.expWe = (we != 0);
    m.expAddr = 4'(a);
    m.expData = 32'(d);
    m.expAlert = (al != 0);
    m.expAlertClient = 4'(ac);
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    in_valid = v.valid;
    in_client = v.client;
    in_qty = v.qty;
    in_clear = v.clear;
    @(negedge clk);
  endtask

  // Releases reset and follows the clearing sweep while an event is held on the input to prove it is ignored.
  task automatic checkSweep(input string tag);
    reset = 1'b0;
    in_valid = 1'b1;
    in_client = 4'd7;
    in_qty = 32'd9;
    in_clear = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s.sweepWe%0d", tag, i), 32'(write_enable), 32'd1);
      checkOutput($sformatf("%s.sweepAddr%0d", tag, i), 32'(address_write), 32'(i));
      checkOutput($sformatf("%s.sweepData%0d", tag, i), data_write, 32'd0);
      checkOutput($sformatf("%s.sweepReady%0d", tag, i), 32'(in_ready), 32'd0);
      checkOutput($sformatf("%s.sweepDone%0d", tag, i), 32'(init_done), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput($sformatf("%s.doneWe", tag), 32'(write_enable), 32'd0);
    checkOutput($sformatf("%s.initDone", tag), 32'(init_done), 32'd1);
    checkOutput($sformatf("%s.readyAfter", tag), 32'(in_ready), 32'd1);
    for (int i = 0; i < 16; i++) checkOutput($sformatf("%s.ramZero%0d", tag, i), mem[i], 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    badWrite4 = 1'b0;
    fillGarbage = 1'b1;
    reset = 1'b1;
    in_valid = 1'b0;
    in_client = 4'd9;
    in_qty = 32'd0;
    in_clear = 1'b0;

    // Columns: valid client qty clear | we addr data | alert alertClient (alert belongs to the previous row's event)
    vecs.push_back(mkVec(1, 3, 5,    0,  1, 3, 5,    0, 0));
    vecs.push_back(mkVec(0, 0, 0,    0,  0, 3, 5,    0, 0));
    vecs.push_back(mkVec(1, 3, 7,    0,  1, 3, 12,   0, 0));
    vecs.push_back(mkVec(1, 2, 10,   0,  1, 2, 10,   0, 0));
    vecs.push_back(mkVec(1, 2, 20,   0,  1, 2, 30,   0, 0));
    vecs.push_back(mkVec(1, 2, 30,   0,  1, 2, 60,   0, 0));
    vecs.push_back(mkVec(1, 5, 999,  0,  1, 5, 999,  0, 0));
    vecs.push_back(mkVec(1, 5, 1,    0,  1, 5, 1000, 0, 0));
    vecs.push_back(mkVec(1, 5, 1,    0,  1, 5, 1001, 1, 5));
    vecs.push_back(mkVec(0, 0, 0,    0,  0, 5, 1001, 0, 0));
    vecs.push_back(mkVec(1, 5, 0,    1,  1, 5, 0,    0, 0));
    vecs.push_back(mkVec(1, 5, 1000, 0,  1, 5, 1000, 0, 0));
    vecs.push_back(mkVec(0, 0, 0,    0,  0, 5, 1000, 1, 5));
    vecs.push_back(mkVec(1, 1, 32'hFFFF_FFF0, 0, 1, 1, 32'hFFFF_FFF0, 0, 0));
    vecs.push_back(mkVec(1, 1, 32'h20, 0, 1, 1, int'(SAT_DATA), 1, 1));
    vecs.push_back(mkVec(1, 2, 1,    0,  1, 2, 61,   0, 0));
    vecs.push_back(mkVec(1, 3, 1,    0,  1, 3, 13,   0, 0));
    vecs.push_back(mkVec(1, 2, 1,    0,  1, 2, 62,   0, 0));
    vecs.push_back(mkVec(0, 0, 0,    0,  0, 2, 62,   0, 0));

    @(negedge clk);
    fillGarbage = 1'b0;
    @(negedge clk);
    checkOutput("rst.inReady", 32'(in_ready), 32'd0);
    checkOutput("rst.initDone", 32'(init_done), 32'd0);
    checkOutput("rst.writeEnable", 32'(write_enable), 32'd0);
    checkOutput("rst.addressRead", 32'(address_read), 32'd0);
    checkOutput("rst.addressWrite", 32'(address_write), 32'd0);
    checkOutput("rst.dataWrite", data_write, 32'd0);
    checkOutput("rst.alertValid", 32'(alert_valid), 32'd0);
    checkOutput("rst.alertClient", 32'(alert_client), 32'd0);

    checkSweep("init");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("row%0d.ready", i), 32'(in_ready), 32'd1);
      checkOutput($sformatf("row%0d.we", i), 32'(write_enable), 32'(vecs[i].expWe));
      checkOutput($sformatf("row%0d.addr", i), 32'(address_write), 32'(vecs[i].expAddr));
      checkOutput($sformatf("row%0d.data", i), data_write, vecs[i].expData);
      checkOutput($sformatf("row%0d.alert", i), 32'(alert_valid), 32'(vecs[i].expAlert));
      if (vecs[i].expAlert)
        checkOutput($sformatf("row%0d.alertClient", i), 32'(alert_client), 32'(vecs[i].expAlertClient));
    end

    checkOutput("ram.client1", mem[1], SAT_DATA);
    checkOutput("ram.client2", mem[2], 32'd62);
    checkOutput("ram.client3", mem[3], 32'd13);
    checkOutput("ram.client5", mem[5], 32'd1000);

    // Reset lands in the cycle after an event on client 4 is accepted.
    applyStimulus(mkVec(1, 4, 7, 0, 0, 0, 0, 0, 0));
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("midRst.weGated", 32'(write_enable), 32'd0);
    @(negedge clk);
    checkOutput("midRst.inReady", 32'(in_ready), 32'd0);
    checkOutput("midRst.initDone", 32'(init_done), 32'd0);
    checkOutput("midRst.writeEnable", 32'(write_enable), 32'd0);
    checkOutput("midRst.alertValid", 32'(alert_valid), 32'd0);
    checkSweep("reinit");
    checkOutput("midRst.noWriteTo4", 32'(badWrite4), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
